spi_target_regs: RTL
====================

Name: spi_target_regs

Overview:
- SPI mode-0 responder (target) that answers the SPI initiator driven by the CPU's SPIAddrIn/SPIDWrite/SPIDRead control-word bits.
- Holds a small 16-bit register file, addressed with the same 12-bit address field the CPU carries in each instruction word.
- Sits off-chip or on-chip as the far end of the SPI link. All SPI pins are oversampled in the CLK domain; no SCLK-clocked logic.

Parameters:
- DEPTH, 16, number of 16-bit words in the register file (power of 2, 2..256).
- SYNC_STAGES, 2, synchronizer flops on SCLK, CS_N and MOSI (≥2).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from the initiator; idles low (mode 0). Must satisfy f(SCLK) ≤ f(CLK)/8.
- CS_N  input  1  SPI chip select, active low.
- MOSI  input  1  initiator to target data, MSB first.
- MISO  output  1  target to initiator data, MSB first.
- BUSY  output  1  high while a frame sequence is in progress (CS_N low after synchronization).
- WR_STB  output  1  one-CLK pulse when a register write commits.
- WR_ADDR  output  12  address of the last committed write.
- WR_DATA  output  16  data of the last committed write.
- ERR  output  1  sticky flag: an out-of-range address was accessed.

Behaviour:
- Reset values: MISO=0, BUSY=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, ERR=0, all registers=16'h0000, state=IDLE.
- Reset is asynchronous; release is used synchronously.
- Pins pass through SYNC_STAGES flops. SCLK rise and fall are detected from the last two synchronized samples. MOSI is taken from the same stage as SCLK.
- Frame format: 16 bits, MSB first. MOSI is sampled on SCLK rise; MISO changes on SCLK fall.
- Frame 1 is the command: bit15=1 write, 0 read; bits14:12 ignored; bits11:0 address.
- Frame 2 is the data: MOSI for a write, MISO for a read.
- Bit counter: 4 bits, counts SCLK rises, wraps 15 to 0 at each frame boundary.
- State IDLE: wait for a synchronized CS_N falling edge, then go to CMD.
  - After RST release, a CS_N that is already low is ignored until it goes high and then low again.
- State CMD: shift MOSI.
  - On the 16th rise: latch the address and R/W bit, then go to DATA.
  - For a read, the register is read in the same CLK cycle and loaded into the MISO shift register. Its MSB is driven on MISO at the next SCLK fall.
- State DATA:
  - Write: shift MOSI. On the 16th rise, the register is written 1 CLK later. WR_STB pulses in that cycle, and WR_ADDR/WR_DATA update in the same cycle.
  - Read: shift the MISO register on each SCLK fall after the first.
  - After the 16th rise, go to TAIL.
- State TAIL: extra SCLK edges are ignored; MISO=0. Leave TAIL on CS_N high.
- MISO is 0 during CMD, TAIL and IDLE.
- Out-of-range address (addr ≥ DEPTH):
  - The write is dropped and WR_STB does not pulse.
  - A read returns 16'h0000.
  - ERR sets at the command's 16th rise and clears only on RST.
- CS_N high in any state (synchronized):
  - Return to IDLE, clear the bit counter, set MISO=0.
  - A partial frame is discarded with no write, and BUSY drops the same cycle.
- CS_N high and the 16th data rise detected in the same CLK cycle: the write commits, then the block goes to IDLE.
- RST mid-frame: the frame is abandoned and the IDLE re-arm rule above applies.
- A read and a write to the same address can never be in flight together; no bypass is needed.

Optional Feature:
- Macro: SPI_TGT_AUTOINC_EN.
- Defined: TAIL is replaced by burst mode.
  - Each further 16-bit frame while CS_N stays low accesses address+1.
  - The address is 12 bits and wraps 12'hFFF to 12'h000.
  - The read prefetch for the next word happens at each 16th rise.
  - The range check and ERR apply to every word.
- Undefined: the TAIL behaviour above; frames after the first data frame are ignored.

Test Plan:
- Write then read: write 0x0003 <- 16'hBEEF. WR_STB is a single pulse with WR_ADDR=0x003 and WR_DATA=16'hBEEF. A new CS read of 0x0003 returns 16'hBEEF on MISO. ERR=0.
- Abort: CS_N goes high after 9 data bits of a write to 0x0005 (value 16'h1234). There is no WR_STB, and a later read of 0x0005 returns 16'h0000. BUSY falls within SYNC_STAGES+1 CLKs.
- Out of range: write 0x0010 <- 16'hAAAA with DEPTH=16. There is no WR_STB and ERR=1. A read of 0x0010 returns 16'h0000. ERR stays 1 until RST.
- Reset mid-frame: assert RST during the CMD frame while CS_N is held low. All outputs are 0. Clocking 32 more SCLKs causes no response. After a CS_N high-low toggle, a read of 0x0000 returns 16'h0000.
- Extra frames (macro off): write 0x0001 <- 16'h00FF followed by a third frame of 16'hFFFF. There is exactly one WR_STB, register 0x0002 stays 16'h0000, and MISO=0 during the third frame.
- Burst (macro on, DEPTH=16):
  - Write starting at 0x000E with 16'h1111, 16'h2222, 16'h3333. 0x000E and 0x000F are written, and the 0x0010 word sets ERR.
  - A burst write starting at 0x0FFF wraps to 0x0000.

Source files
------------

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target with a small 16-bit register file.
// All SPI pins are oversampled in the CLK domain; there is no SCLK-clocked logic.
// Frame 1 is the command (bit15 = write, bits11:0 = address), frame 2 the data.
// Optional burst auto-increment after the first data word: define SPI_TGT_AUTOINC_EN.

module spi_target_regs #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        CS_N,
  input  logic        MOSI,
  output logic        MISO,
  output logic        BUSY,
  output logic        WR_STB,
  output logic [11:0] WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        ERR
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_L = 13'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_t;

  // Address range check against the register file depth.
  function automatic logic in_range(input logic [11:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise_s, fall_s, cs_fall_s, last_rise_s;

  state_t      state_r, state_s;
  logic [3:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic [11:0] addr_r;
  logic        rw_r;
  logic [15:0] miso_sh_r;
  logic        miso_r, busy_r, err_r;
  logic        wr_pend_r;
  logic [11:0] pend_addr_r;
  logic [15:0] pend_data_r;
  logic        wr_stb_r;
  logic [11:0] wr_addr_r;
  logic [15:0] wr_data_r;
  logic [15:0] mem_r [DEPTH];

  logic [11:0] cmd_addr_s;
  logic        cmd_wr_s;
  logic [15:0] data_word_s;
  logic [15:0] cmd_rd_s;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign rise_s      = sclk_s & ~sclk_d;
  assign fall_s      = ~sclk_s & sclk_d;
  assign cs_fall_s   = cs_d & ~cs_s;
  assign last_rise_s = rise_s && (bit_cnt_r == 4'd15);

  // The 16th bit arrives on MOSI in the same cycle the last rise is seen.
  assign cmd_addr_s  = {shift_r[10:0], mosi_s};
  assign cmd_wr_s    = shift_r[14];
  assign data_word_s = {shift_r[14:0], mosi_s};
  assign cmd_rd_s    = in_range(cmd_addr_s) ? mem_r[cmd_addr_s[AW-1:0]] : 16'h0000;

`ifdef SPI_TGT_AUTOINC_EN
  logic [11:0] next_addr_s;
  logic [15:0] next_rd_s;
  assign next_addr_s = addr_r + 12'd1;
  assign next_rd_s   = in_range(next_addr_s) ? mem_r[next_addr_s[AW-1:0]] : 16'h0000;
`endif

  assign MISO    = miso_r;
  assign BUSY    = busy_r;
  assign WR_STB  = wr_stb_r;
  assign WR_ADDR = wr_addr_r;
  assign WR_DATA = wr_data_r;
  assign ERR     = err_r;

  // Pin synchronizers plus one extra sample of SCLK/CS_N for edge detection.
  // CS_N resets low so a CS_N already low at reset release gives no falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync <= {SYNC_STAGES{1'b0}};
      cs_sync   <= {SYNC_STAGES{1'b0}};
      mosi_sync <= {SYNC_STAGES{1'b0}};
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_s = CMD;
        else           state_s = IDLE;
      end
      CMD: begin
        if (cs_s)             state_s = IDLE;
        else if (last_rise_s) state_s = DATA;
        else                  state_s = CMD;
      end
      DATA: begin
        if (cs_s)             state_s = IDLE;
`ifdef SPI_TGT_AUTOINC_EN
        else if (last_rise_s) state_s = DATA;
`else
        else if (last_rise_s) state_s = TAIL;
`endif
        else                  state_s = DATA;
      end
      TAIL: begin
        if (cs_s) state_s = IDLE;
        else      state_s = TAIL;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: shifting, command latch, read prefetch, write commit, error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 16'h0000;
      addr_r      <= 12'h000;
      rw_r        <= 1'b0;
      miso_sh_r   <= 16'h0000;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      wr_pend_r   <= 1'b0;
      pend_addr_r <= 12'h000;
      pend_data_r <= 16'h0000;
      wr_stb_r    <= 1'b0;
      wr_addr_r   <= 12'h000;
      wr_data_r   <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 16'h0000;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != IDLE);
      wr_stb_r  <= 1'b0;
      wr_pend_r <= 1'b0;

      // A completed write word commits one cycle after its last rise.
      if (wr_pend_r) begin
        mem_r[pend_addr_r[AW-1:0]] <= pend_data_r;
        wr_stb_r  <= 1'b1;
        wr_addr_r <= pend_addr_r;
        wr_data_r <= pend_data_r;
      end

      if (rise_s) shift_r <= {shift_r[14:0], mosi_s};

      if (cs_s || (state_r == IDLE)) bit_cnt_r <= 4'd0;
      else if (rise_s)               bit_cnt_r <= bit_cnt_r + 4'd1;

      case (state_r)
        CMD: begin
          if (!cs_s && last_rise_s) begin
            addr_r <= cmd_addr_s;
            rw_r   <= cmd_wr_s;
            if (!in_range(cmd_addr_s)) err_r <= 1'b1;
            if (!cmd_wr_s) miso_sh_r <= cmd_rd_s;
          end
        end
        DATA: begin
          // Commits even if CS_N rises in the same cycle as the last rise.
          if (last_rise_s && rw_r) begin
            if (in_range(addr_r)) begin
              wr_pend_r   <= 1'b1;
              pend_addr_r <= addr_r;
              pend_data_r <= data_word_s;
            end else begin
              err_r <= 1'b1;
            end
          end
`ifdef SPI_TGT_AUTOINC_EN
          if (last_rise_s && !cs_s) begin
            addr_r <= next_addr_s;
            if (!rw_r) begin
              miso_sh_r <= next_rd_s;
              if (!in_range(next_addr_s)) err_r <= 1'b1;
            end
          end
`endif
          if (!rw_r && fall_s) begin
            miso_r    <= miso_sh_r[15];
            miso_sh_r <= {miso_sh_r[14:0], 1'b0};
          end
        end
        default: begin
        end
      endcase

      // MISO is only ever driven from the shifter while a data word is active.
      if (state_s != DATA) miso_r <= 1'b0;
    end
  end

endmodule
